// File: rtl/gpio_cfg_pkg.sv
// Shared definitions for the per-pad GPIO configuration shift chain:
// word width, field bit positions, drive-mode encodings and FSM states.
package gpio_cfg_pkg;

    // Configuration word width (only 13 is supported by the field map).
    localparam int CFG_W = 13;

    // Bit positions of the decoded fields inside the configuration word.
    localparam int BIT_MGMT_ENA    = 0;
    localparam int BIT_OUTENB      = 1;
    localparam int BIT_HOLD_OVR    = 2;
    localparam int BIT_INP_DIS     = 3;
    localparam int BIT_IB_MODE_SEL = 4;
    localparam int BIT_AN_EN       = 5;
    localparam int BIT_AN_SEL      = 6;
    localparam int BIT_AN_POL      = 7;
    localparam int BIT_SLOW_SLEW   = 8;
    localparam int BIT_VTRIP_SEL   = 9;
    localparam int BIT_DM_LO       = 10;
    localparam int BIT_DM_HI       = 12;

    // Drive-mode encodings of the dm field.
    localparam logic [2:0] DM_ANALOG    = 3'b000;
    localparam logic [2:0] DM_INPUT     = 3'b001;
    localparam logic [2:0] DM_PUSH_PULL = 3'b110;

    // State encodings kept as plain constants so other tools can match them.
    localparam logic [1:0] ST_INIT_ENC     = 2'd0;
    localparam logic [1:0] ST_IDLE_ENC     = 2'd1;
    localparam logic [1:0] ST_SHIFTING_ENC = 2'd2;
    localparam logic [1:0] ST_APPLY_ENC    = 2'd3;

    typedef enum logic [1:0] {
        ST_INIT     = ST_INIT_ENC,
        ST_IDLE     = ST_IDLE_ENC,
        ST_SHIFTING = ST_SHIFTING_ENC,
        ST_APPLY    = ST_APPLY_ENC
    } cfg_state_t;

    // A full word has been shifted once the counter reaches this value.
    localparam logic [3:0] SHIFT_CNT_MAX = 4'd13;

    // Shift counter increment that sticks at a full word.
    function automatic logic [3:0] sat_inc(input logic [3:0] cnt);
        return (cnt >= SHIFT_CNT_MAX) ? SHIFT_CNT_MAX : cnt + 4'd1;
    endfunction

endpackage

// File: rtl/gpio_config_shifter.sv
// One pad's configuration stage: a 13-bit serial shift register that is
// committed into the active configuration word on a load strobe, with the
// active word decoded into individual pad control fields.
module gpio_config_shifter
    import gpio_cfg_pkg::*;
#(
    parameter int CFG_W = 13
) (
    input  logic             wb_clk_i,
    input  logic             wb_rstn_i,
    input  logic [CFG_W-1:0] gpio_defaults,
    input  logic             reload_defaults,
    input  logic             serial_shift,
    input  logic             serial_data_in,
    input  logic             serial_load,
    output logic             serial_data_out,
    output logic [CFG_W-1:0] cfg_word,
    output logic             mgmt_ena,
    output logic             outenb,
    output logic             hold_ovr,
    output logic             inp_dis,
    output logic             ib_mode_sel,
    output logic             an_en,
    output logic             an_sel,
    output logic             an_pol,
    output logic             slow_slew,
    output logic             vtrip_sel,
    output logic [2:0]       dm,
    output logic             cfg_update,
    output logic             short_load
);

    cfg_state_t       state_reg,  state_next;
    logic [CFG_W-1:0] shift_reg,  shift_next;
    logic [CFG_W-1:0] active_reg, active_next;
    logic [3:0]       cnt_reg,    cnt_next;
    logic             short_reg,  short_next;
    logic             update_reg, update_next;

    // Next-state logic; reload_defaults overrides everything else.
    always_comb begin
        state_next  = state_reg;
        shift_next  = shift_reg;
        active_next = active_reg;
        cnt_next    = cnt_reg;
        short_next  = short_reg;
        update_next = 1'b0;

        if (reload_defaults) begin
            state_next = ST_INIT;
            short_next = 1'b0;
        end else begin
            case (state_reg)
                ST_INIT: begin
                    shift_next  = gpio_defaults;
                    active_next = gpio_defaults;
                    cnt_next    = 4'd0;
                    update_next = 1'b1;
                    state_next  = ST_IDLE;
                end
                ST_IDLE, ST_SHIFTING: begin
                    if (serial_shift) begin
                        shift_next = {shift_reg[CFG_W-2:0], serial_data_in};
                        cnt_next   = sat_inc(cnt_reg);
                        state_next = ST_SHIFTING;
                    end
                    // A load in the same cycle as a shift commits the
                    // post-shift contents, so the count judged is the new one.
                    if (serial_load) begin
                        if (cnt_next < SHIFT_CNT_MAX) begin
                            short_next = 1'b1;
                        end
                        state_next = ST_APPLY;
                    end
                end
                ST_APPLY: begin
                    // Strobes arriving here are dropped on purpose.
                    active_next = shift_reg;
                    update_next = 1'b1;
                    cnt_next    = 4'd0;
                    state_next  = ST_IDLE;
                end
                default: begin
                    state_next = ST_INIT;
                end
            endcase
        end
    end

    // State registers with synchronous active-low reset to the pad defaults.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rstn_i) begin
            state_reg  <= ST_INIT;
            shift_reg  <= gpio_defaults;
            active_reg <= gpio_defaults;
            cnt_reg    <= 4'd0;
            short_reg  <= 1'b0;
            update_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            shift_reg  <= shift_next;
            active_reg <= active_next;
            cnt_reg    <= cnt_next;
            short_reg  <= short_next;
            update_reg <= update_next;
        end
    end

    assign serial_data_out = shift_reg[CFG_W-1];
    assign cfg_word        = active_reg;
    assign cfg_update      = update_reg;
    assign short_load      = short_reg;

    assign mgmt_ena    = active_reg[BIT_MGMT_ENA];
    assign outenb      = active_reg[BIT_OUTENB];
    assign hold_ovr    = active_reg[BIT_HOLD_OVR];
    assign inp_dis     = active_reg[BIT_INP_DIS];
    assign ib_mode_sel = active_reg[BIT_IB_MODE_SEL];
    assign an_en       = active_reg[BIT_AN_EN];
    assign an_sel      = active_reg[BIT_AN_SEL];
    assign an_pol      = active_reg[BIT_AN_POL];
    assign slow_slew   = active_reg[BIT_SLOW_SLEW];
    assign vtrip_sel   = active_reg[BIT_VTRIP_SEL];
    assign dm          = active_reg[BIT_DM_HI:BIT_DM_LO];

endmodule

// File: tb/tb_gpio_config_shifter.sv
// Two chained pad stages driven by directed scenarios and random strobes,
// checked every cycle against a behavioural model of the chain.
module tb_gpio_config_shifter;
    import gpio_cfg_pkg::*;

    localparam logic [CFG_W-1:0] DEF0 = 13'h0402;
    localparam logic [CFG_W-1:0] DEF1 = 13'h1A55;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn = 1'b0, reload = 1'b0, shift = 1'b0, din = 1'b0, load = 1'b0;

    logic             sdo0, sdo1, upd0, upd1, short0, short1;
    logic [CFG_W-1:0] cfg0, cfg1;
    logic [2:0]       dm0, dm1;
    logic me0, oe0, ho0, id0, ib0, ae0, as0, ap0, ss0, vt0;
    logic me1, oe1, ho1, id1, ib1, ae1, as1, ap1, ss1, vt1;

    gpio_config_shifter #(.CFG_W(CFG_W)) dut0 (
        .wb_clk_i(clk), .wb_rstn_i(rstn), .gpio_defaults(DEF0),
        .reload_defaults(reload), .serial_shift(shift), .serial_data_in(din),
        .serial_load(load), .serial_data_out(sdo0), .cfg_word(cfg0),
        .mgmt_ena(me0), .outenb(oe0), .hold_ovr(ho0), .inp_dis(id0),
        .ib_mode_sel(ib0), .an_en(ae0), .an_sel(as0), .an_pol(ap0),
        .slow_slew(ss0), .vtrip_sel(vt0), .dm(dm0),
        .cfg_update(upd0), .short_load(short0)
    );

    gpio_config_shifter #(.CFG_W(CFG_W)) dut1 (
        .wb_clk_i(clk), .wb_rstn_i(rstn), .gpio_defaults(DEF1),
        .reload_defaults(reload), .serial_shift(shift), .serial_data_in(sdo0),
        .serial_load(load), .serial_data_out(sdo1), .cfg_word(cfg1),
        .mgmt_ena(me1), .outenb(oe1), .hold_ovr(ho1), .inp_dis(id1),
        .ib_mode_sel(ib1), .an_en(ae1), .an_sel(as1), .an_pol(ap1),
        .slow_slew(ss1), .vtrip_sel(vt1), .dm(dm1),
        .cfg_update(upd1), .short_load(short1)
    );

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input int inst,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] actual=%0h required=%0h at %0t",
                     name, inst, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Per pad: bits held in the chain, committed word, bits received since the
    // last commit (capped at a full word), sticky short flag, and which one-cycle
    // action (restore defaults / commit) is owed on the next clock.
    localparam int NONE = 0, OWE_DEFAULTS = 1, OWE_COMMIT = 2;
    logic [CFG_W-1:0] m_chain  [2];
    logic [CFG_W-1:0] m_active [2];
    logic [CFG_W-1:0] m_def    [2];
    int               m_bits   [2];
    logic             m_short  [2];
    logic             m_pulse  [2];
    int               m_owed   [2];

    initial begin
        m_def[0] = DEF0;
        m_def[1] = DEF1;
    end

    task automatic model_step(input int i, input logic bit_in);
        if (!rstn) begin
            m_chain[i]  = m_def[i];
            m_active[i] = m_def[i];
            m_bits[i]   = 0;
            m_short[i]  = 1'b0;
            m_pulse[i]  = 1'b0;
            m_owed[i]   = OWE_DEFAULTS;
        end else if (reload) begin
            m_owed[i]  = OWE_DEFAULTS;
            m_short[i] = 1'b0;
            m_pulse[i] = 1'b0;
        end else if (m_owed[i] == OWE_DEFAULTS) begin
            m_chain[i]  = m_def[i];
            m_active[i] = m_def[i];
            m_bits[i]   = 0;
            m_pulse[i]  = 1'b1;
            m_owed[i]   = NONE;
        end else if (m_owed[i] == OWE_COMMIT) begin
            m_active[i] = m_chain[i];
            m_bits[i]   = 0;
            m_pulse[i]  = 1'b1;
            m_owed[i]   = NONE;
        end else begin
            m_pulse[i] = 1'b0;
            if (shift) begin
                m_chain[i] = (m_chain[i] << 1) | CFG_W'(bit_in);
                if (m_bits[i] < CFG_W) m_bits[i] = m_bits[i] + 1;
            end
            if (load) begin
                if (m_bits[i] < CFG_W) m_short[i] = 1'b1;
                m_owed[i] = OWE_COMMIT;
            end
        end
    endtask

    // Advance the model on each clock; pad 1 sees pad 0's pre-edge chain output.
    always @(posedge clk) begin
        logic chain_bit;
        chain_bit = m_chain[0][CFG_W-1];
        model_step(0, din);
        model_step(1, chain_bit);
    end

    // Compare both pads against the model away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("cfg_word", 0, 32'(cfg0), 32'(m_active[0]));
            check("fields", 0, 32'({dm0, vt0, ss0, ap0, as0, ae0, ib0, id0, ho0, oe0, me0}), 32'(m_active[0]));
            check("serial_data_out", 0, 32'(sdo0), 32'(m_chain[0][CFG_W-1]));
            check("cfg_update", 0, 32'(upd0), 32'(m_pulse[0]));
            check("short_load", 0, 32'(short0), 32'(m_short[0]));
            check("cfg_word", 1, 32'(cfg1), 32'(m_active[1]));
            check("fields", 1, 32'({dm1, vt1, ss1, ap1, as1, ae1, ib1, id1, ho1, oe1, me1}), 32'(m_active[1]));
            check("serial_data_out", 1, 32'(sdo1), 32'(m_chain[1][CFG_W-1]));
            check("cfg_update", 1, 32'(upd1), 32'(m_pulse[1]));
            check("short_load", 1, 32'(short1), 32'(m_short[1]));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic s, input logic d, input logic l,
                        input logic r, input logic rn = 1'b1);
        @(negedge clk);
        shift  = s;
        din    = d;
        load   = l;
        reload = r;
        rstn   = rn;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_word(input logic [CFG_W-1:0] w);
        for (int b = CFG_W - 1; b >= 0; b--) step(1'b1, w[b], 1'b0, 1'b0);
    endtask

    // Load strobe, then one cycle in APPLY, leaving the committed word visible.
    task automatic commit();
        step(1'b0, 1'b0, 1'b1, 1'b0);
        idle(2);
    endtask

    initial begin
        logic [CFG_W-1:0] w;
        logic [CFG_W-1:0] d0, d1;
        int pulses;
        d0 = DEF0;
        d1 = DEF1;

        // Reset held for three edges, then released.
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cmp_en = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            if (upd0) pulses++;
        end
        $display("txn reset_release cfg0=%h dm0=%b pulses=%0d", cfg0, dm0, pulses);
        check("init_pulses", 0, 32'(pulses), 32'd1);
        check("lit_cfg_reset", 0, 32'(cfg0), 32'h0402);
        check("lit_outenb_reset", 0, 32'(oe0), 32'd1);
        check("lit_dm_reset", 0, 32'(dm0), 32'(DM_INPUT));

        // Full 13-bit load.
        w = 13'h1809;
        send_word(w);
        commit();
        $display("txn full_load cfg0=%h short0=%b dm0=%b", cfg0, short0, dm0);
        check("lit_cfg_full", 0, 32'(cfg0), 32'h1809);
        check("lit_short_full", 0, 32'(short0), 32'd0);
        check("lit_dm_full", 0, 32'(dm0), 32'(DM_PUSH_PULL));
        check("lit_update_apply", 0, 32'(upd0), 32'd1);

        // Short load is sticky until reload_defaults.
        for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 1'b0, 1'b0);
        commit();
        $display("txn short_load short0=%b", short0);
        check("lit_short_set", 0, 32'(short0), 32'd1);
        w = 13'h0777;
        send_word(w);
        commit();
        $display("txn full_after_short cfg0=%h short0=%b", cfg0, short0);
        check("lit_short_sticky", 0, 32'(short0), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        $display("txn reload short0=%b cfg0=%h", short0, cfg0);
        check("lit_short_cleared", 0, 32'(short0), 32'd0);
        check("lit_cfg_reload", 0, 32'(cfg0), 32'h0402);

        // Shift and load together on the 13th bit.
        w = 13'h0A5B;
        for (int b = CFG_W - 1; b >= 1; b--) step(1'b1, w[b], 1'b0, 1'b0);
        step(1'b1, w[0], 1'b1, 1'b0);
        idle(2);
        $display("txn shift_and_load cfg0=%h short0=%b", cfg0, short0);
        check("lit_cfg_same_cycle", 0, 32'(cfg0), 32'h0A5B);
        check("lit_short_same_cycle", 0, 32'(short0), 32'd0);

        // Reset in the middle of shifting discards the partial word.
        for (int k = 0; k < 7; k++) step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        $display("txn mid_shift_reset cfg0=%h sdo0=%b cfg1=%h sdo1=%b", cfg0, sdo0, cfg1, sdo1);
        check("lit_cfg_midreset", 0, 32'(cfg0), 32'(DEF0));
        check("lit_sdo_midreset", 0, 32'(sdo0), 32'(d0[CFG_W-1]));
        check("lit_cfg_midreset", 1, 32'(cfg1), 32'(DEF1));
        check("lit_sdo_midreset", 1, 32'(sdo1), 32'(d1[CFG_W-1]));
        idle(1);
        // Six more bits must still count as short if the counter was cleared.
        for (int k = 0; k < 6; k++) step(1'b1, 1'b0, 1'b0, 1'b0);
        commit();
        $display("txn cnt_cleared short0=%b", short0);
        check("lit_cnt_cleared", 0, 32'(short0), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);

        // Two chained pads receive 26 bits then a common load.
        w = 13'h0155;
        send_word(w);
        w = 13'h1A6C;
        send_word(w);
        commit();
        $display("txn chain cfg0=%h cfg1=%h dm1=%b", cfg0, cfg1, dm1);
        check("lit_chain_first", 0, 32'(cfg0), 32'h1A6C);
        check("lit_chain_second", 1, 32'(cfg1), 32'h0155);
        check("lit_chain_dm", 1, 32'(dm1), 32'(DM_ANALOG));

        // Random strobes, reloads and occasional resets.
        for (int k = 0; k < 3000; k++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 99) < 8), 1'($urandom_range(0, 99) < 2),
                 1'($urandom_range(0, 199) != 0));
        end
        idle(4);
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gpio_config_shifter.md
GPIO_CONFIG_SHIFTER -- requirements
Module: gpio_config_shifter

Interface
REQ-001 SHALL have parameter CFG_W, default 13, the configuration word width; only 13 is supported.
REQ-002 SHALL have port wb_clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port wb_rstn_i, input, 1, reset; it is synchronous and active-low.
REQ-004 SHALL have port gpio_defaults, input, 13, the pad default word from the defaults block; static.
REQ-005 SHALL have port reload_defaults, input, 1, a one-cycle request to restore the defaults.
REQ-006 SHALL have port serial_shift, input, 1, a one-cycle strobe to shift one bit.
REQ-007 SHALL have port serial_data_in, input, 1, the serial bit, sampled when serial_shift=1.
REQ-008 SHALL have port serial_load, input, 1, a one-cycle strobe to commit the shift register.
REQ-009 SHALL have port serial_data_out, output, 1, the chain output, equal to shift_reg[12].
REQ-010 SHALL have port cfg_word, output, 13, the active configuration.
REQ-011 SHALL have decoded outputs, each driven from the active word: mgmt_ena[0], outenb[1], hold_ovr[2], inp_dis[3], ib_mode_sel[4], an_en[5], an_sel[6], an_pol[7], slow_slew[8], vtrip_sel[9], dm[12:10] (3 bits).
REQ-012 SHALL have port cfg_update, output, 1, a one-cycle pulse when the active word changes source.
REQ-013 SHALL have port short_load, output, 1, a sticky flag set when a commit follows fewer than 13 shifts.

Function
REQ-014 SHALL use FSM states INIT, IDLE, SHIFTING and APPLY.
REQ-015 SHALL behave in INIT as follows: shift_reg and the active word load gpio_defaults, cfg_update=1, then go to IDLE.
REQ-016 SHALL, in IDLE or SHIFTING with serial_shift=1, do shift_reg <= {shift_reg[11:0], serial_data_in}, increment shift_cnt saturating at 13, and go to or stay in SHIFTING.
REQ-017 SHALL, in IDLE or SHIFTING with serial_load=1, go to APPLY.
REQ-018 SHALL, in APPLY, set the active word to shift_reg, assert cfg_update for that cycle, clear shift_cnt, and return to IDLE.
REQ-019 SHALL, when entering APPLY with shift_cnt<13, set short_load; short_load clears only on reset or reload_defaults.
REQ-020 SHALL, when serial_shift and serial_load are both 1 in the same cycle, perform the shift and then commit the post-shift value in APPLY.
REQ-021 SHALL, in APPLY, ignore serial_shift and serial_load; strobes arriving in APPLY are dropped.
REQ-022 SHALL, on reload_defaults=1 in any state, go to INIT next cycle and clear short_load; it has priority over shift and load.
REQ-023 SHALL otherwise hold shift_reg when serial_shift=0, so serial_data_out changes only after a shift, APPLY, or INIT.
REQ-024 SHALL give all outputs a latency of 1 cycle from the state that updates them, driven directly from registers.

Reset
REQ-025 SHALL, while wb_rstn_i=0 at a clock edge, set state=INIT, shift_cnt=0, short_load=0, cfg_update=0, and set shift_reg and the active word to gpio_defaults.
REQ-026 SHALL treat reset during SHIFTING or APPLY as discarding partial shifts; the first cycle after release is INIT.

Structure
REQ-027 SHALL place bit-index constants, the CFG_W localparam, the dm encodings (000 analog, 001 input, 110 push-pull) and the state enum in shared package gpio_cfg_pkg.
REQ-028 SHALL contain no sub-module; the field decode is inline.
REQ-029 SHALL instantiate the block once per pad, with serial_data_out feeding the next pad's serial_data_in.

Verification
REQ-030 SHALL verify: gpio_defaults=13'h0402 and reset released -> cfg_word=0402, outenb=1, dm=001, a single cfg_update pulse.
REQ-031 SHALL verify: 13 shifts of 13'h1809 MSB-first then load -> cfg_word=1809 one cycle after APPLY, short_load=0, dm=110.
REQ-032 SHALL verify: 5 shifts then load -> short_load=1 and stays 1 through later full loads until reload_defaults.
REQ-033 SHALL verify: shift and load in the same cycle on the 13th bit -> the committed word includes that bit.
REQ-034 SHALL verify: wb_rstn_i low mid-SHIFTING after 7 bits -> cfg_word=gpio_defaults, shift_cnt=0, and serial_data_out equals gpio_defaults[12].
REQ-035 SHALL verify: two chained instances given 26 shifts then a common load -> the first instance holds the second word sent and the second instance holds the first.
